ce_ls_scale_arb: RTL and testbench

- Packet-granular round-robin arbiter that shares one LS-scaling datapath between two channel-estimate streams (e.g. two antennas / two pilot symbols).
- Sits directly upstream of the LS scaler. Each ready/valid stream with sop/eop framing is granted the scaler for one whole packet (sop to eop), with no interleaving.
- Emits the stream tag and a packet-length check per packet.

---
 rtl/ce_ls_scale_arb_pkg.sv | 26 ++
 rtl/ce_ls_scale_arb_if.sv | 18 +
 rtl/ce_ls_scale_arb_sat_cnt.sv | 27 ++
 rtl/ce_ls_scale_arb.sv | 181 ++++++++++++++++++
 tb/tb_ce_ls_scale_arb.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ce_ls_scale_arb_pkg.sv
// Shared CE definitions: arbiter state encoding, requester count, saturating add.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ce_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Add a small increment to a counter value, clamping at max instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [31:0] max,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, val} + 33'(inc);
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/ce_ls_scale_arb_if.sv
// Sample stream with sop/eop framing and a per-packet length field.
// Latency: n/a (wiring only).
// Backpressure: a beat moves only on a cycle where valid and ready are both high.
interface ce_ls_scale_arb_if #(
    parameter int WDATA = 35,
    parameter int WPTS  = 12
);
    logic             valid;
    logic             ready;
    logic             sop;
    logic             eop;
    logic [WDATA-1:0] real_dat;
    logic [WDATA-1:0] imag_dat;
    logic [WPTS-1:0]  fftpts;

    modport master (output valid, sop, eop, real_dat, imag_dat, fftpts, input ready);
    modport slave  (input valid, sop, eop, real_dat, imag_dat, fftpts, output ready);
endinterface

// File: rtl/ce_ls_scale_arb_sat_cnt.sv
// W-bit saturating counter adding 0..3 per cycle, with synchronous clear.
// Latency: count visible one cycle after the increment request.
// Backpressure: none; saturates at all-ones.
module ce_sat_cnt
    import ce_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_sync,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    localparam logic [31:0] CNT_MAX = 32'((33'd1 << W) - 33'd1);

    // Count up by inc, holding at all-ones once reached.
    always_ff @(posedge clk) begin
        if (rst_sync || clr) begin
            cnt <= '0;
        end else if (inc != 2'd0) begin
            cnt <= W'(sat_add(32'(cnt), CNT_MAX, inc));
        end
    end

endmodule

// File: rtl/ce_ls_scale_arb.sv
// Packet-granular round-robin arbiter feeding the LS scaler from two streams (stats: CE_LS_ARB_STATS_EN).
// Latency: zero-latency datapath mux while granted; one idle arbitration cycle before each packet.
// Backpressure: granted stream's ready follows m.ready; loser stalls; non-sop beats in IDLE are accepted and dropped.
module ce_ls_scale_arb
    import ce_pkg::*;
#(
    parameter int WDATA = 35,
    parameter int WPTS  = 12,
    parameter int WCNT  = 16
) (
    input  logic                 clk,
    input  logic                 rst_sync,
    ce_ls_scale_arb_if.slave     s0,
    ce_ls_scale_arb_if.slave     s1,
    ce_ls_scale_arb_if.master    m,
    output logic                 m_sel,
    output logic                 busy,
    output logic                 len_err,
    output logic [WCNT-1:0]      drop_cnt
`ifdef CE_LS_ARB_STATS_EN
    ,
    input  logic                 ovf,
    output logic [WCNT-1:0]      ovf_pkt0,
    output logic [WCNT-1:0]      ovf_pkt1
`endif
);

    localparam int WB = WPTS + 1;

    arb_state_t      state, state_nxt;
    logic            last;
    logic [WB-1:0]   beat_cnt;
    logic [WB-1:0]   beat_inc;
    logic [WB-1:0]   len_eff;
    logic [WPTS-1:0] len_q;
    logic            cand0, cand1;
    logic            drop0, drop1;
    logic            xfer, eop_xfer;

    assign cand0    = s0.valid & s0.sop;
    assign cand1    = s1.valid & s1.sop;
    assign xfer     = m.valid & m.ready;
    assign eop_xfer = xfer & m.eop;
    assign busy     = (state != IDLE);
    // A latched length of zero stands for a full 2^WPTS-beat packet.
    assign len_eff  = (len_q == '0) ? {1'b1, {WPTS{1'b0}}} : {1'b0, len_q};
    assign beat_inc = WB'(sat_add(32'(beat_cnt), 32'({WB{1'b1}}), 2'd1));

    // Arbitration, grant mux and ready steering.
    always_comb begin
        state_nxt  = state;
        m.valid    = 1'b0;
        m.sop      = 1'b0;
        m.eop      = 1'b0;
        m.real_dat = '0;
        m.imag_dat = '0;
        m.fftpts   = '0;
        m_sel      = 1'b0;
        s0.ready   = 1'b0;
        s1.ready   = 1'b0;
        drop0      = 1'b0;
        drop1      = 1'b0;
        case (state)
            IDLE: begin
                drop0    = s0.valid & ~s0.sop;
                drop1    = s1.valid & ~s1.sop;
                s0.ready = drop0;
                s1.ready = drop1;
                if (cand0 && cand1) begin
                    state_nxt = last ? GRANT0 : GRANT1;
                end else if (cand0) begin
                    state_nxt = GRANT0;
                end else if (cand1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                m.valid    = s0.valid;
                m.sop      = s0.sop;
                m.eop      = s0.eop;
                m.real_dat = s0.real_dat;
                m.imag_dat = s0.imag_dat;
                m.fftpts   = len_q;
                s0.ready   = m.ready;
                if (s0.valid && m.ready && s0.eop) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                m.valid    = s1.valid;
                m.sop      = s1.sop;
                m.eop      = s1.eop;
                m.real_dat = s1.real_dat;
                m.imag_dat = s1.imag_dat;
                m.fftpts   = len_q;
                m_sel      = 1'b1;
                s1.ready   = m.ready;
                if (s1.valid && m.ready && s1.eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer, length latch, beat count and length-error pulse.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
            len_q    <= '0;
            len_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_err <= eop_xfer && (beat_inc != len_eff);
            if (state == IDLE && state_nxt != IDLE) begin
                len_q    <= (state_nxt == GRANT1) ? s1.fftpts : s0.fftpts;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_inc;
            end
            if (eop_xfer) begin
                last <= m_sel;
            end
        end
    end

    ce_sat_cnt #(.W(WCNT)) u_drop_cnt (
        .clk      (clk),
        .rst_sync (rst_sync),
        .clr      (1'b0),
        .inc      ({drop0 & drop1, drop0 ^ drop1}),
        .cnt      (drop_cnt)
    );

`ifdef CE_LS_ARB_STATS_EN
    logic sel_d, eop_d, xfer_d, sticky;
    logic ovf_hit, pkt_ovf;

    // ovf from the scaler belongs to the beat moved one cycle earlier.
    assign ovf_hit = ovf & xfer_d;
    assign pkt_ovf = eop_d & (sticky | ovf_hit);

    // Delay select/eop to line up with ovf and track overflow within the packet.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            sel_d  <= 1'b0;
            eop_d  <= 1'b0;
            xfer_d <= 1'b0;
            sticky <= 1'b0;
        end else begin
            sel_d  <= m_sel;
            eop_d  <= eop_xfer;
            xfer_d <= xfer;
            if (eop_d) begin
                sticky <= 1'b0;
            end else if (ovf_hit) begin
                sticky <= 1'b1;
            end
        end
    end

    ce_sat_cnt #(.W(WCNT)) u_ovf_pkt0 (
        .clk      (clk),
        .rst_sync (rst_sync),
        .clr      (1'b0),
        .inc      ({1'b0, pkt_ovf & ~sel_d}),
        .cnt      (ovf_pkt0)
    );

    ce_sat_cnt #(.W(WCNT)) u_ovf_pkt1 (
        .clk      (clk),
        .rst_sync (rst_sync),
        .clr      (1'b0),
        .inc      ({1'b0, pkt_ovf & sel_d}),
        .cnt      (ovf_pkt1)
    );
`endif

endmodule

// File: tb/tb_ce_ls_scale_arb.sv
// Self-checking bench for ce_ls_scale_arb: queued packet sources, packet-level reference model.
// Latency: n/a.
// Backpressure: sink ready driven constant, toggling or random per scenario.
module tb_ce_ls_scale_arb;
    import ce_pkg::*;

    localparam int WDATA = 35;
    localparam int WPTS  = 12;
    localparam int WCNT  = 16;

    typedef struct {
        logic             sel;
        logic             sop;
        logic             eop;
        logic [WDATA-1:0] re;
        logic [WDATA-1:0] im;
        logic [WPTS-1:0]  pts;
    } beat_t;

    logic clk = 1'b0;
    logic rst_sync;
    logic m_sel, busy, len_err;
    logic [WCNT-1:0] drop_cnt;
`ifdef CE_LS_ARB_STATS_EN
    logic [WCNT-1:0] ovf_pkt0, ovf_pkt1;
`endif

    always #5 clk = ~clk;

    ce_ls_scale_arb_if #(.WDATA(WDATA), .WPTS(WPTS)) s0_if ();
    ce_ls_scale_arb_if #(.WDATA(WDATA), .WPTS(WPTS)) s1_if ();
    ce_ls_scale_arb_if #(.WDATA(WDATA), .WPTS(WPTS)) m_if ();

    ce_ls_scale_arb #(.WDATA(WDATA), .WPTS(WPTS), .WCNT(WCNT)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .s0       (s0_if),
        .s1       (s1_if),
        .m        (m_if),
        .m_sel    (m_sel),
        .busy     (busy),
        .len_err  (len_err),
        .drop_cnt (drop_cnt)
`ifdef CE_LS_ARB_STATS_EN
        ,
        .ovf      (1'b0),
        .ovf_pkt0 (ovf_pkt0),
        .ovf_pkt1 (ovf_pkt1)
`endif
    );

    beat_t q0[$], q1[$], exp0[$], exp1[$], out_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_xfer, eop_cyc, lenerr_n, lenerr_cyc, busy_n, mirror_bad, mvalid_n, rdy1_n;
    int rdy_mode = 0;
    bit vld_rand = 0;
    bit rst_req = 0;
    bit chk_s0 = 0;

    task automatic clear_stats();
        first_xfer = -1; eop_cyc = -1; lenerr_n = 0; lenerr_cyc = -1;
        busy_n = 0; mirror_bad = 0; mvalid_n = 0; rdy1_n = 0;
    endtask

    // Queue one packet on a source; the first 'keep' beats are expected at the sink.
    task automatic push_pkt(input int src, input int nbeats, input int pts, input bit with_sop, input int keep);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.sel = src[0];
            b.sop = with_sop && (i == 0);
            b.eop = (i == nbeats - 1);
            b.re  = WDATA'({$urandom(), $urandom()});
            b.im  = WDATA'({$urandom(), $urandom()});
            b.pts = (i == 0) ? WPTS'(pts) : WPTS'($urandom());
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            b.pts = WPTS'(pts);
            if (with_sop && i < keep) begin
                if (src == 0) exp0.push_back(b); else exp1.push_back(b);
            end
        end
    endtask

    // Beats seen at the sink versus the per-source expected streams, plus packet-interleave violations.
    function automatic int sb_mismatches();
        int bad = 0;
        bit in_pkt = 0;
        logic cur = 1'b0;
        beat_t e;
        foreach (out_q[i]) begin
            if (in_pkt && out_q[i].sel != cur) bad++;
            if (out_q[i].sop) begin in_pkt = 1; cur = out_q[i].sel; end
            if (out_q[i].eop) in_pkt = 0;
            if ((out_q[i].sel ? exp1.size() : exp0.size()) == 0) begin
                bad++;
            end else begin
                e = out_q[i].sel ? exp1.pop_front() : exp0.pop_front();
                if (e.sop !== out_q[i].sop || e.eop !== out_q[i].eop || e.re !== out_q[i].re ||
                    e.im !== out_q[i].im || e.pts !== out_q[i].pts) bad++;
            end
        end
        bad += exp0.size() + exp1.size();
        exp0.delete(); exp1.delete(); out_q.delete();
        return bad;
    endfunction

    // One clock: drive sources from their queues, then observe outputs at the falling edge.
    task automatic cycle();
        bit s0_pend;
        beat_t o, d;
        @(posedge clk);
        #1;
        cyc++;
        rst_sync = rst_req;
        s0_pend = (q0.size() > 0);
        if (q0.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
            s0_if.valid = 1'b1; s0_if.sop = q0[0].sop; s0_if.eop = q0[0].eop;
            s0_if.real_dat = q0[0].re; s0_if.imag_dat = q0[0].im; s0_if.fftpts = q0[0].pts;
        end else begin
            s0_if.valid = 1'b0; s0_if.sop = 1'b0; s0_if.eop = 1'b0;
        end
        if (q1.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
            s1_if.valid = 1'b1; s1_if.sop = q1[0].sop; s1_if.eop = q1[0].eop;
            s1_if.real_dat = q1[0].re; s1_if.imag_dat = q1[0].im; s1_if.fftpts = q1[0].pts;
        end else begin
            s1_if.valid = 1'b0; s1_if.sop = 1'b0; s1_if.eop = 1'b0;
        end
        case (rdy_mode)
            0:       m_if.ready = 1'b1;
            1:       m_if.ready = (cyc % 2 == 0);
            2:       m_if.ready = 1'($urandom_range(0, 1));
            default: m_if.ready = 1'b0;
        endcase
        @(negedge clk);
        if (s0_if.valid && s0_if.ready) d = q0.pop_front();
        if (s1_if.valid && s1_if.ready) begin d = q1.pop_front(); rdy1_n++; end
        if (m_if.valid) mvalid_n++;
        if (m_if.valid && m_if.ready) begin
            o.sel = m_sel; o.sop = m_if.sop; o.eop = m_if.eop;
            o.re = m_if.real_dat; o.im = m_if.imag_dat; o.pts = m_if.fftpts;
            out_q.push_back(o);
            if (first_xfer < 0) first_xfer = cyc;
            if (m_if.eop) eop_cyc = cyc;
        end
        if (len_err) begin lenerr_n++; lenerr_cyc = cyc; end
        if (busy) busy_n++;
        if (chk_s0 && s0_pend && busy && (s0_if.ready !== m_if.ready || s1_if.ready !== 1'b0)) mirror_bad++;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
    endtask

    task automatic run_until_empty(input int extra, input int budget, output bit timeout);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        timeout = (q0.size() > 0 || q1.size() > 0);
        repeat (extra) cycle();
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        repeat (3) cycle();
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_if.valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b want 0", len_err); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        rst_req = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_packet();
        bit to;
        int start;
        do_reset(); clear_stats(); rdy_mode = 0; vld_rand = 0;
        push_pkt(0, 4, 4, 1, 4);
        start = cyc + 1;
        run_until_empty(3, 50, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %b want 0", to); end
        checks++; if (first_xfer - start !== 1) begin errors++; $display("FAIL single_bubble got %0d want 1", first_xfer - start); end
        checks++; if (busy_n !== 4) begin errors++; $display("FAIL single_busy_cycles got %0d want 4", busy_n); end
        checks++; if (lenerr_n !== 0) begin errors++; $display("FAIL single_len_err got %0d want 0", lenerr_n); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL single_data got mismatches want 0"); end
    endtask

    task automatic test_alternation();
        bit to;
        logic [3:0] seq = '0;
        int npkt = 0;
        do_reset(); clear_stats(); rdy_mode = 0; vld_rand = 0;
        for (int i = 0; i < 4; i++) push_pkt(i % 2, 2, 2, 1, 2);
        run_until_empty(3, 100, to);
        foreach (out_q[i]) if (out_q[i].sop) begin seq = {seq[2:0], out_q[i].sel}; npkt++; end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL alt_timeout got %b want 0", to); end
        checks++; if (npkt !== 4 || seq !== 4'b0101) begin errors++; $display("FAIL alt_order got %b (%0d pkts) want 0101 (4 pkts)", seq, npkt); end
        checks++; if (busy_n !== 8) begin errors++; $display("FAIL alt_busy_cycles got %0d want 8", busy_n); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL alt_data got mismatches want 0"); end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset(); clear_stats(); rdy_mode = 1; vld_rand = 0; chk_s0 = 1;
        push_pkt(0, 6, 6, 1, 6);
        push_pkt(1, 2, 2, 1, 2);
        run_until_empty(3, 100, to);
        chk_s0 = 0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b want 0", to); end
        checks++; if (mirror_bad !== 0) begin errors++; $display("FAIL bp_ready_mirror got %0d bad cycles want 0", mirror_bad); end
        checks++; if (lenerr_n !== 0) begin errors++; $display("FAIL bp_len_err got %0d want 0", lenerr_n); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL bp_data got mismatches want 0"); end
    endtask

    task automatic test_drop();
        bit to;
        do_reset(); clear_stats(); rdy_mode = 0; vld_rand = 0;
        push_pkt(1, 3, 5, 0, 0);
        run_until_empty(1, 20, to);
        checks++; if (rdy1_n !== 3) begin errors++; $display("FAIL drop_s1_ready got %0d want 3", rdy1_n); end
        checks++; if (mvalid_n !== 0) begin errors++; $display("FAIL drop_m_valid got %0d want 0", mvalid_n); end
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_cnt got %0d want 3", drop_cnt); end
        push_pkt(0, 2, 1, 0, 0);
        push_pkt(1, 2, 1, 0, 0);
        run_until_empty(1, 20, to);
        checks++; if (drop_cnt !== 16'd7) begin errors++; $display("FAIL drop_cnt_dual got %0d want 7", drop_cnt); end
        checks++; if (mvalid_n !== 0 || to !== 1'b0) begin errors++; $display("FAIL drop_dual_m_valid got %0d timeout %b want 0 0", mvalid_n, to); end
    endtask

    task automatic test_len_err();
        bit to;
        do_reset(); clear_stats(); rdy_mode = 0; vld_rand = 0;
        push_pkt(0, 6, 8, 1, 6);
        run_until_empty(3, 50, to);
        checks++; if (lenerr_n !== 1) begin errors++; $display("FAIL lenerr_count got %0d want 1", lenerr_n); end
        checks++; if (lenerr_cyc !== eop_cyc + 1) begin errors++; $display("FAIL lenerr_timing got %0d want %0d", lenerr_cyc, eop_cyc + 1); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL lenerr_data got mismatches want 0"); end
        clear_stats();
        push_pkt(0, 4096, 0, 1, 4096);
        run_until_empty(3, 5000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL long_timeout got %b want 0", to); end
        checks++; if (lenerr_n !== 0) begin errors++; $display("FAIL long_len_err got %0d want 0", lenerr_n); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL long_data got mismatches want 0"); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0;
        do_reset(); clear_stats(); rdy_mode = 0; vld_rand = 0;
        push_pkt(0, 8, 8, 1, 3);
        while (out_q.size() < 3 && n < 50) begin cycle(); n++; end
        rdy_mode = 3; rst_req = 1'b1;
        cycle();
        rst_req = 1'b0; rdy_mode = 0; clear_stats();
        run_until_empty(1, 50, to);
        checks++; if (busy_n !== 0 || mvalid_n !== 0) begin errors++; $display("FAIL rstmid_idle got busy %0d valid %0d want 0 0", busy_n, mvalid_n); end
        checks++; if (drop_cnt !== 16'd5) begin errors++; $display("FAIL rstmid_drop_cnt got %0d want 5", drop_cnt); end
        push_pkt(0, 2, 2, 1, 2);
        push_pkt(1, 2, 2, 1, 2);
        run_until_empty(3, 50, to);
        checks++;
        if (out_q.size() < 4) begin
            errors++; $display("FAIL rstmid_next_grant got %0d beats want at least 4", out_q.size());
        end else if (out_q[3].sel !== 1'b0 || out_q[3].sop !== 1'b1) begin
            errors++; $display("FAIL rstmid_next_grant got sel %b sop %b want 0 1", out_q[3].sel, out_q[3].sop);
        end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL rstmid_data got mismatches want 0"); end
    endtask

    task automatic test_random();
        bit to;
        int exp_err = 0;
        int n, pts, src;
        do_reset(); clear_stats(); rdy_mode = 2; vld_rand = 1;
        for (int i = 0; i < 16; i++) begin
            src = $urandom_range(0, 1);
            n   = $urandom_range(1, 6);
            pts = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : n;
            if (n != pts) exp_err++;
            push_pkt(src, n, pts, 1, n);
        end
        run_until_empty(4, 3000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout got %b want 0", to); end
        checks++; if (lenerr_n !== exp_err) begin errors++; $display("FAIL rand_len_err got %0d want %0d", lenerr_n, exp_err); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rand_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (sb_mismatches() !== 0) begin errors++; $display("FAIL rand_data got mismatches want 0"); end
        vld_rand = 0; rdy_mode = 0;
    endtask

    initial begin
        rst_sync = 1'b1;
        s0_if.valid = 1'b0; s0_if.sop = 1'b0; s0_if.eop = 1'b0;
        s0_if.real_dat = '0; s0_if.imag_dat = '0; s0_if.fftpts = '0;
        s1_if.valid = 1'b0; s1_if.sop = 1'b0; s1_if.eop = 1'b0;
        s1_if.real_dat = '0; s1_if.imag_dat = '0; s1_if.fftpts = '0;
        m_if.ready = 1'b1;
        clear_stats();
        test_reset();
        test_single_packet();
        test_alternation();
        test_backpressure();
        test_drop();
        test_len_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
